// File: rtl/accum_host_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : accum_host_sequencer_if
// Description : Bundles the job/config, load and readback streams, and the
//               kernel array/start/done port of the accumulate host sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface accum_host_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic                     start;
    logic [ADDR_W:0]          job_len;
    logic signed [DATA_W-1:0] cfg_init_i;
    logic signed [DATA_W-1:0] cfg_init_acc;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic                     kres;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic                     controlArr;
    logic                     controlArrWEnable_a;
    logic [ADDR_W-1:0]        controlArrAddr_a;
    logic signed [DATA_W-1:0] controlArrWData_a;
    logic signed [DATA_W-1:0] controlArrRData_a;
    logic                     r_enable;
    logic                     w_enable;
    logic                     result;
    logic signed [DATA_W-1:0] init_i;
    logic signed [DATA_W-1:0] init_acc;

    modport master (
        input  start, job_len, cfg_init_i, cfg_init_acc, in_valid, in_data,
               out_ready, controlArrRData_a, w_enable, result,
        output busy, done, error, kres, in_ready, out_valid, out_data,
               controlArr, controlArrWEnable_a, controlArrAddr_a,
               controlArrWData_a, r_enable, init_i, init_acc
    );

    modport slave (
        output start, job_len, cfg_init_i, cfg_init_acc, in_valid, in_data,
               out_ready, controlArrRData_a, w_enable, result,
        input  busy, done, error, kres, in_ready, out_valid, out_data,
               controlArr, controlArrWEnable_a, controlArrAddr_a,
               controlArrWData_a, r_enable, init_i, init_acc
    );
endinterface
`default_nettype wire

// File: rtl/accum_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : accum_host_sequencer
// Description : Loads a job into the kernel array, starts the accumulate
//               kernel, waits for done (with watchdog), then streams the array
//               contents back out.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_host_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    accum_host_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_RD    = 3'd4;
    localparam logic [2:0] S_RW    = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;
    localparam logic [2:0] S_FIN   = 3'd7;

    localparam logic [ADDR_W:0] c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     c_WD_LIMIT = 32'(TIMEOUT - 1);
    localparam bit              c_WD_EN    = (TIMEOUT != 0);

    logic [2:0]               r_state,      w_state_nxt;
    logic [ADDR_W:0]          r_len,        w_len_nxt;
    logic [ADDR_W:0]          r_cnt,        w_cnt_nxt;
    logic [31:0]              r_wdog,       w_wdog_nxt;
    logic signed [DATA_W-1:0] r_init_i,     w_init_i_nxt;
    logic signed [DATA_W-1:0] r_init_acc,   w_init_acc_nxt;
    logic                     r_busy,       w_busy_nxt;
    logic                     r_done,       w_done_nxt;
    logic                     r_error,      w_error_nxt;
    logic                     r_kres,       w_kres_nxt;
    logic                     r_out_valid,  w_out_valid_nxt;
    logic signed [DATA_W-1:0] r_out_data,   w_out_data_nxt;
    logic                     r_ctrl,       w_ctrl_nxt;
    logic                     r_we,         w_we_nxt;
    logic [ADDR_W-1:0]        r_addr,       w_addr_nxt;
    logic signed [DATA_W-1:0] r_wdata,      w_wdata_nxt;
    logic                     r_ren,        w_ren_nxt;
    logic [ADDR_W:0]          w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_wdog      <= '0;
            r_init_i    <= '0;
            r_init_acc  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_kres      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ctrl      <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ren       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wdog      <= w_wdog_nxt;
            r_init_i    <= w_init_i_nxt;
            r_init_acc  <= w_init_acc_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_kres      <= w_kres_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_ctrl      <= w_ctrl_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_ren       <= w_ren_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_wdog_nxt      = r_wdog;
        w_init_i_nxt    = r_init_i;
        w_init_acc_nxt  = r_init_acc;
        w_error_nxt     = r_error;
        w_kres_nxt      = r_kres;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_ctrl_nxt      = r_ctrl;
        w_we_nxt        = 1'b0;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_ren_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_len_nxt      = bus.job_len;
                    w_init_i_nxt   = bus.cfg_init_i;
                    w_init_acc_nxt = bus.cfg_init_acc;
                    w_error_nxt    = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = (bus.job_len == '0) ? S_START : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_cnt[ADDR_W-1:0];
                    w_wdata_nxt = bus.in_data;
                    w_cnt_nxt   = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                // The final load write is on the bus this cycle, while the host still owns the port.
                w_ctrl_nxt  = 1'b0;
                w_ren_nxt   = 1'b1;
                w_wdog_nxt  = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.w_enable) begin
                    w_kres_nxt  = bus.result;
                    w_ctrl_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_addr_nxt  = '0;
                    w_state_nxt = (r_len == '0) ? S_FIN : S_RD;
                end else if (c_WD_EN && (r_wdog == c_WD_LIMIT)) begin
                    w_error_nxt = 1'b1;
                    w_ctrl_nxt  = 1'b1;
                    w_state_nxt = S_FIN;
                end else begin
                    w_wdog_nxt = r_wdog + 32'd1;
                end
            end
            S_RD: begin
                // Address is already presented on entry, so RData is valid during RW.
                w_addr_nxt  = r_cnt[ADDR_W-1:0];
                w_state_nxt = S_RW;
            end
            S_RW: begin
                w_out_data_nxt  = bus.controlArrRData_a;
                w_out_valid_nxt = 1'b1;
                w_state_nxt     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = w_cnt_inc;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_addr_nxt  = w_cnt_inc[ADDR_W-1:0];
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_done_nxt = (w_state_nxt == S_FIN);
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
    end

    assign bus.in_ready            = (r_state == S_LOAD);
    assign bus.busy                = r_busy;
    assign bus.done                = r_done;
    assign bus.error               = r_error;
    assign bus.kres                = r_kres;
    assign bus.out_valid           = r_out_valid;
    assign bus.out_data            = r_out_data;
    assign bus.controlArr          = r_ctrl;
    assign bus.controlArrWEnable_a = r_we;
    assign bus.controlArrAddr_a    = r_addr;
    assign bus.controlArrWData_a   = r_wdata;
    assign bus.r_enable            = r_ren;
    assign bus.init_i              = r_init_i;
    assign bus.init_acc            = r_init_acc;
endmodule
`default_nettype wire

// File: tb/tb_accum_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_host_sequencer
// Description : Bench for accum_host_sequencer with a behavioural array RAM and
//               prefix-sum kernel; outputs are scored against running sums.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_host_sequencer;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_host_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    accum_host_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          len;
        logic [63:0] acc;
        int          pat;
        int          rdy;
        int          gap;
        int          klat;
        bit          err;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [63:0] mem [DEPTH];
    logic [63:0] job_in [DEPTH];
    logic [63:0] exp_q [$];
    logic [63:0] k_acc;
    int          k_cnt = 0;
    int          k_lat = 0;
    int          cur_len = 0;
    int          rdy_mode = 0;
    int          wr_cnt = 0;
    int          ren_cnt = 0;
    int          done_cnt = 0;
    int          last_hs = -100;
    int          ren_cyc = 0;
    int          done_cyc = 0;
    int          last_waddr = -1;
    bit          hold_pend = 1'b0;
    logic [63:0] hold_data;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Array RAM (1-cycle read latency) plus the kernel: on start it waits k_lat
    // cycles, rewrites mem[0..len-1] with prefix sums seeded by init_acc, and
    // raises done (w_enable) until the host takes the port back.
    always @(posedge clk) begin
        if (!rst_n) begin
            k_cnt = 0;
            bus.w_enable          <= 1'b0;
            bus.result            <= 1'b0;
            bus.controlArrRData_a <= '0;
        end else begin
            if (bus.controlArr) begin
                bus.controlArrRData_a <= mem[bus.controlArrAddr_a];
                if (bus.controlArrWEnable_a) mem[bus.controlArrAddr_a] = bus.controlArrWData_a;
            end
            if (bus.r_enable) begin
                k_cnt = k_lat;
                bus.w_enable <= 1'b0;
            end else if (k_cnt == 1) begin
                k_acc = bus.init_acc;
                for (int i = 0; i < cur_len; i++) begin
                    k_acc  = k_acc + mem[i];
                    mem[i] = k_acc;
                end
                bus.result   <= k_acc[0];
                bus.w_enable <= 1'b1;
                k_cnt = 0;
            end else if (k_cnt > 1) begin
                k_cnt = k_cnt - 1;
            end else if (bus.w_enable && bus.controlArr) begin
                bus.w_enable <= 1'b0;
            end
        end
    end

    // Readback sink and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (rst_n) begin
            if (hold_pend) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_data", bus.out_data, hold_data);
            end
            hold_pend = bus.out_valid && !bus.out_ready;
            hold_data = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_out_word", 1, 0);
                else check("out_word", bus.out_data, exp_q.pop_front());
                check("out_gap_ge3", (cyc - last_hs >= 3), 1);
                last_hs = cyc;
            end
            if (bus.controlArrWEnable_a) begin
                check("write_owned", bus.controlArr, 1);
                check("write_addr", bus.controlArrAddr_a, wr_cnt);
                if (wr_cnt < DEPTH) check("write_data", bus.controlArrWData_a, job_in[wr_cnt]);
                last_waddr = bus.controlArrAddr_a;
                wr_cnt++;
            end
            if (bus.r_enable) begin
                ren_cnt++;
                ren_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic clear_counters();
        wr_cnt = 0; ren_cnt = 0; last_hs = -100; ren_cyc = 0; done_cyc = 0; last_waddr = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_controlArr"}, bus.controlArr, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_error"}, bus.error, 0);
        check({tag, "_kres"}, bus.kres, 0);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_r_enable"}, bus.r_enable, 0);
        check({tag, "_wenable"}, bus.controlArrWEnable_a, 0);
        check({tag, "_addr"}, bus.controlArrAddr_a, 0);
        check({tag, "_wdata"}, bus.controlArrWData_a, 0);
        check({tag, "_init_i"}, bus.init_i, 0);
        check({tag, "_init_acc"}, bus.init_acc, 0);
    endtask

    task automatic start_job(input int len, input logic [63:0] acc0);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.job_len      = 11'(len);
        bus.cfg_init_acc = acc0;
        bus.cfg_init_i   = ~acc0;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        check("error_cleared", bus.error, 0);
        check("init_acc_out", bus.init_acc, acc0);
        check("init_i_out", bus.init_i, ~acc0);
    endtask

    task automatic load(input int n, input int gap);
        int idx;
        int guard;
        bit v;
        idx = 0;
        guard = 0;
        while (idx < n && guard < 20000) begin
            v = ($urandom_range(0, 99) >= gap);
            bus.in_valid = v;
            bus.in_data  = job_in[idx];
            if (v && bus.in_ready) idx++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        check("load_accepted", idx, n);
        if (gap == 0) check("load_one_per_cycle", guard, n);
    endtask

    task automatic run_job(input int len, input logic [63:0] acc0, input int pat,
                           input int rmode, input int gap, input int klat, input bit exp_err);
        logic [63:0] sum;
        int guard;
        sum = acc0;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            job_in[i] = (pat == 0) ? 64'(i + 1) : {$urandom, $urandom};
            sum = sum + job_in[i];
            if (!exp_err) exp_q.push_back(sum);
        end
        rdy_mode = rmode;
        k_lat    = klat;
        cur_len  = len;
        clear_counters();
        start_job(len, acc0);
        if (len > 0) load(len, gap);
        guard = 0;
        while (bus.done !== 1'b1 && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", bus.done, 1);
        if (bus.done === 1'b1) begin
            check("busy_at_done", bus.busy, 0);
            check("error_at_done", bus.error, exp_err);
            check("ctrl_at_done", bus.controlArr, 1);
            if (!exp_err) check("kres", bus.kres, sum[0]);
            @(negedge clk);
            check("done_one_cycle", bus.done, 0);
            check("write_count", wr_cnt, len);
            check("r_enable_cycles", ren_cnt, 1);
            check("words_missing", exp_q.size(), 0);
            if (len > 0) check("last_write_addr", last_waddr, len - 1);
            if (exp_err) check("timeout_run_cycles", done_cyc - ren_cyc, TIMEOUT);
            else if (len > 0) check("done_after_last_hs", done_cyc - last_hs, 1);
            if (exp_err) begin
                repeat (3) @(negedge clk);
                check("error_held", bus.error, 1);
            end
        end
    endtask

    initial begin
        int saved_done;
        int guard;
        bus.start = 1'b0; bus.job_len = '0; bus.cfg_init_i = '0; bus.cfg_init_acc = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;

        //          len   acc                    pat rdy gap klat err
        vecs[0] = '{4,    64'd0,                 0,  0,  0,  3,  1'b0};
        vecs[1] = '{1024, 64'h0123_4567_89ab_cdef, 1,  0,  0,  5,  1'b0};
        vecs[2] = '{37,   64'hffff_ffff_ffff_fff0, 1,  1,  20, 2,  1'b0};
        vecs[3] = '{0,    64'd5,                 0,  0,  0,  4,  1'b0};
        vecs[4] = '{5,    64'd9,                 1,  0,  0,  0,  1'b1};
        vecs[5] = '{3,    64'd1,                 1,  0,  0,  1,  1'b0};
        vecs[6] = '{64,   64'h8000_0000_0000_0000, 1,  2,  30, 10, 1'b0};
        vecs[7] = '{1,    64'd2,                 1,  1,  0,  7,  1'b0};
        for (int v = 0; v < 8; v++)
            run_job(vecs[v].len, vecs[v].acc, vecs[v].pat, vecs[v].rdy, vecs[v].gap,
                    vecs[v].klat, vecs[v].err);

        for (int r = 0; r < 6; r++)
            run_job($urandom_range(0, 200), {$urandom, $urandom}, 1, $urandom_range(0, 2),
                    $urandom_range(0, 40), $urandom_range(1, 10), 1'b0);

        // Reset in the middle of LOAD: immediate return to reset values, no done.
        for (int i = 0; i < 8; i++) job_in[i] = 64'(i * 7 + 3);
        cur_len = 8; k_lat = 3; rdy_mode = 0; exp_q.delete(); clear_counters();
        start_job(8, 64'h55);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = job_in[i];
            @(negedge clk);
        end
        saved_done = done_cnt;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_reset_vals("rst_in_load");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("no_done_on_load_abort", done_cnt, saved_done);
        run_job(6, 64'd100, 1, 0, 10, 3, 1'b0);

        // Reset while the kernel is running.
        job_in[0] = 64'd11; job_in[1] = 64'd22;
        cur_len = 2; k_lat = 0; exp_q.delete(); clear_counters();
        start_job(2, 64'd0);
        load(2, 0);
        guard = 0;
        while (bus.r_enable !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("run_entered", bus.r_enable, 1);
        repeat (3) @(negedge clk);
        check("kernel_owns_port", bus.controlArr, 0);
        saved_done = done_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_in_run");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT + 4) @(negedge clk);
        check("no_done_on_run_abort", done_cnt, saved_done);
        run_job(9, 64'd7, 0, 1, 0, 6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
